// File: rtl/pool_pkg.sv
// Shared pool-path constants: default geometry, derived pooled-grid sizes and coordinate widths.
// Also holds the per-pixel phase encoding used by the 2x2 window generator.
package pool_pkg;

  localparam int DATA_W = 69;
  localparam int CH     = 8;
  localparam int IMG_X  = 24;
  localparam int IMG_Y  = 24;
  localparam int POOL_X = IMG_X / 2;
  localparam int POOL_Y = IMG_Y / 2;
  localparam int ROW_W  = $clog2(POOL_Y);
  localparam int COL_W  = $clog2(POOL_X);

  // Position of a pixel inside its 2x2 window, encoded as {row odd, col odd}.
  typedef enum logic [1:0] {
    PH_HOLD_TOP  = 2'b00,
    PH_WRITE_TOP = 2'b01,
    PH_HOLD_BOT  = 2'b10,
    PH_EMIT      = 2'b11
  } phase_e;

  function automatic phase_e pix_phase(input logic row_odd, input logic col_odd);
    return phase_e'({row_odd, col_odd});
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row buffer of top-window pixel pairs: synchronous write, asynchronous read.
// Latency: read is combinational; no backpressure, contents are not reset.
module pool_line_buf #(
  parameter int DEPTH = 12,
  parameter int WIDTH = 1104,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping 2x2 pooling windows, all channels in parallel.
// Latency: 1 cycle from the odd-row/odd-col pixel to a one-cycle win_valid pulse.
// Valid-only on both sides, no backpressure; POOL_WIN_SOF_SYNC_EN adds in_sof/frame_err.
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int DATA_W = pool_pkg::DATA_W,
  parameter int CH     = pool_pkg::CH,
  parameter int IMG_X  = pool_pkg::IMG_X,
  parameter int IMG_Y  = pool_pkg::IMG_Y,
  localparam int PIX_W = CH * DATA_W,
  localparam int WR_W  = $clog2(IMG_Y / 2),
  localparam int WC_W  = $clog2(IMG_X / 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_data,
  output logic             win_valid,
  output logic [PIX_W-1:0] win_00,
  output logic [PIX_W-1:0] win_01,
  output logic [PIX_W-1:0] win_10,
  output logic [PIX_W-1:0] win_11,
  output logic [WR_W-1:0]  win_row,
  output logic [WC_W-1:0]  win_col,
  output logic             frame_done
`ifdef POOL_WIN_SOF_SYNC_EN
  ,
  input  logic             in_sof,
  output logic             frame_err
`endif
);

  localparam int CX_W = $clog2(IMG_X);
  localparam int CY_W = $clog2(IMG_Y);
  localparam logic [CX_W-1:0] COL_LAST = CX_W'(IMG_X - 1);
  localparam logic [CY_W-1:0] ROW_LAST = CY_W'(IMG_Y - 1);

  logic [CX_W-1:0]    col_q, col_d, col_cur;
  logic [CY_W-1:0]    row_q, row_d, row_cur;
  logic [PIX_W-1:0]   h_q, h_d;
  logic [PIX_W-1:0]   w00_q, w00_d, w01_q, w01_d, w10_q, w10_d, w11_q, w11_d;
  logic [WR_W-1:0]    wrow_q, wrow_d;
  logic [WC_W-1:0]    wcol_q, wcol_d;
  logic               wvld_q, wvld_d;
  logic               fdone_q, fdone_d;
  logic               sof_hit;
  phase_e             phase;

  logic               lb_we;
  logic [WC_W-1:0]    lb_addr;
  logic [2*PIX_W-1:0] lb_wdata, lb_rdata;

`ifdef POOL_WIN_SOF_SYNC_EN
  logic frame_err_q, frame_err_d;

  assign sof_hit     = in_valid & in_sof;
  // Any start-of-frame seen away from the origin means the stream slipped.
  assign frame_err_d = frame_err_q | (sof_hit & ((row_q != '0) | (col_q != '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`else
  assign sof_hit = 1'b0;
`endif

  always_comb begin
    col_cur  = sof_hit ? '0 : col_q;
    row_cur  = sof_hit ? '0 : row_q;
    phase    = pix_phase(row_cur[0], col_cur[0]);
    lb_addr  = WC_W'(col_cur >> 1);
    lb_wdata = {h_q, in_data};

    col_d   = col_q;
    row_d   = row_q;
    h_d     = h_q;
    w00_d   = w00_q;
    w01_d   = w01_q;
    w10_d   = w10_q;
    w11_d   = w11_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    wvld_d  = 1'b0;
    fdone_d = 1'b0;
    lb_we   = 1'b0;

    if (in_valid) begin
      if (col_cur == COL_LAST) begin
        col_d = '0;
        row_d = (row_cur == ROW_LAST) ? '0 : row_cur + CY_W'(1);
      end else begin
        col_d = col_cur + CX_W'(1);
        row_d = row_cur;
      end

      case (phase)
        PH_HOLD_TOP,
        PH_HOLD_BOT:  h_d   = in_data;
        PH_WRITE_TOP: lb_we = 1'b1;
        PH_EMIT: begin
          w00_d   = lb_rdata[2*PIX_W-1:PIX_W];
          w01_d   = lb_rdata[PIX_W-1:0];
          w10_d   = h_q;
          w11_d   = in_data;
          wrow_d  = WR_W'(row_cur >> 1);
          wcol_d  = WC_W'(col_cur >> 1);
          wvld_d  = 1'b1;
          fdone_d = (row_cur == ROW_LAST) && (col_cur == COL_LAST);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      h_q     <= '0;
      w00_q   <= '0;
      w01_q   <= '0;
      w10_q   <= '0;
      w11_q   <= '0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      wvld_q  <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      h_q     <= h_d;
      w00_q   <= w00_d;
      w01_q   <= w01_d;
      w10_q   <= w10_d;
      w11_q   <= w11_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      wvld_q  <= wvld_d;
      fdone_q <= fdone_d;
    end
  end

  // Writes only on even rows, reads only on odd rows, so one address serves both ports.
  pool_line_buf #(
    .DEPTH (IMG_X / 2),
    .WIDTH (2 * PIX_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (lb_wdata),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  assign win_valid  = wvld_q;
  assign win_00     = w00_q;
  assign win_01     = w01_q;
  assign win_10     = w10_q;
  assign win_11     = w11_q;
  assign win_row    = wrow_q;
  assign win_col    = wcol_q;
  assign frame_done = fdone_q;

endmodule

// File: doc/pool_window_gen.md
# pool_window_gen

Converts the raster-ordered ReLU output stream (one pixel per cycle, all channels in parallel) into the non-overlapping 2x2 windows consumed by the max-pool stage. It sits between the ReLU stage and the pool stage. It buffers one even image row and emits, for every odd-row/odd-column pixel, the four window taps for every channel. The pool stage has no backpressure, so this block is valid-only on both sides.

## Interface
Parameters:
- DATA_W, 69: signed sample width per channel.
- CH, 8: channels processed in parallel.
- IMG_X, 24: input row length in pixels; must be even.
- IMG_Y, 24: input rows per frame; must be even.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  the in_data pixel is accepted this cycle.
- in_data  in  CH*DATA_W  one pixel; channel c at [c*DATA_W +: DATA_W], signed.
- win_valid  out  1  window taps valid; one-cycle pulse per window.
- win_00, win_01, win_10, win_11  out  CH*DATA_W each  taps (row,col) top-left, top-right, bottom-left, bottom-right; same channel packing.
- win_row, win_col  out  $clog2(IMG_Y/2), $clog2(IMG_X/2)  output-grid coordinates of the window.
- frame_done  out  1  pulses together with win_valid on the last window of the frame (IMG_X/2-1, IMG_Y/2-1).

## Operation
- The column counter `col` runs 0..IMG_X-1 and the row counter `row` runs 0..IMG_Y-1. Both advance only on in_valid. `col` wraps to 0 and increments `row`. `row` wraps to 0 after IMG_Y-1, so frames run back to back.
- Even row, even col: the pixel is captured in the hold register `h`.
- Even row, odd col: {h, in_data} is written to line-buffer entry col>>1.
- Odd row, even col: the pixel is captured in `h`.
- Odd row, odd col: entry col>>1 is read. The window registers load {top-left, top-right} = entry, win_10 = h, and win_11 = in_data. Coordinates are row>>1 and col>>1. win_valid is set.
- Each frame produces exactly (IMG_X/2)*(IMG_Y/2) windows. The default is 144.
- Data passes through bit-exact with no arithmetic. Signedness is preserved.
- in_valid gaps of any length are allowed. State holds during gaps.

## Timing
- Latency is 1 cycle: win_valid rises on the edge after the accepted odd/odd pixel, and it is high for exactly one cycle.
- The maximum window rate is one per 2 cycles. There are no back-to-back win_valid pulses.
- Line-buffer read and write never collide, because writes happen only on even rows and reads only on odd rows.
- Reset values: win_valid=0, frame_done=0, all win_* = 0, win_row = win_col = 0. Counters and `h` reset to 0.
- Line-buffer contents are not reset. They are always rewritten before being read.
- Reset asserted mid-frame aborts the frame. The first in_valid after rst deasserts is pixel (0,0).
- frame_done is asserted only alongside win_valid on the final window.

## Configuration
- POOL_WIN_SOF_SYNC_EN defined:
  - Adds input in_sof (1 bit) and output frame_err (1 bit, reset 0).
  - in_sof together with in_valid forces that pixel to be treated as (0,0). The counters continue from there.
  - If the counters were not already at (0,0) when in_sof is accepted, frame_err is set. frame_err is sticky until rst. The partial frame's windows are not emitted.
- Undefined: no extra ports. The counters free-run, and alignment depends solely on reset.

## Structure
- Shared package pool_pkg holds the default DATA_W, CH, IMG_X, IMG_Y, the derived POOL_X=IMG_X/2 and POOL_Y=IMG_Y/2, and the coordinate widths. pool_layer's constants are taken from the same package.
- One sub-module, pool_line_buf: depth IMG_X/2, width 2*CH*DATA_W, one synchronous write port, one asynchronous read port, no reset.
- Counters, the hold register, and the output registers live in the top module.

## Test plan
- **Ramp frame:** pixel value p = row*24+col in all channels. The window at (r,c) must have 00=(2r)*24+2c, 01=+1, 10=+24, 11=+25. The run must produce 144 win_valid pulses, and frame_done must pulse only with window (11,11).
- **Signed extremes:** channel 3 carries -2^68 and channel 5 carries 2^68-1 at alternating pixels. The taps must match bit-exactly per channel, with no cross-channel leakage.
- **Random in_valid gaps (30% idle):** window contents and count must equal the gap-free run. win_valid must lag the odd/odd pixel by exactly 1 cycle.
- **Back-to-back frames:** two frames are sent with no gap. The second frame's first window is (0,0) and frame_done pulses twice in total.
- **Async reset mid-frame:** rst is asserted at pixel (7,13), between clock edges. All outputs must go to 0 immediately. A following full frame must yield correct windows starting at (0,0).
- **POOL_WIN_SOF_SYNC_EN:** in_sof is asserted at pixel (5,4). frame_err must go to 1 and stay there. The next 144 windows must match the ramp with the origin at that pixel.
